// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: owns the PC, issues in-order word reads and buffers returned words for decode.
// Redirects flush the buffer and drop responses belonging to requests already in flight.
module instr_fetch_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [31:0]     dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic [6:0]      dec_opcode
);

   localparam int unsigned AW  = $clog2(BUF_DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned OW  = CW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {RUN, DRAIN} state_e;

   state_e          state_q, state_d;
   logic            started_q;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   if_rd_q, if_rd_d, if_wr_q, if_wr_d;
   logic [XLEN-1:0] if_pc_q [BUF_DEPTH];
   logic [XLEN-1:0] if_pc_d [BUF_DEPTH];
   logic [XLEN-1:0] buf_pc_q [BUF_DEPTH];
   logic [XLEN-1:0] buf_pc_d [BUF_DEPTH];
   logic [31:0]     buf_instr_q [BUF_DEPTH];
   logic [31:0]     buf_instr_d [BUF_DEPTH];
   logic            dec_valid_q, dec_valid_d;
   logic [31:0]     dec_instr_q, dec_instr_d;
   logic [XLEN-1:0] dec_pc_q, dec_pc_d;

   logic [OW-1:0]   occupancy;
   logic            req_fire, rsp_drop, push, pop;

   always_comb begin
      occupancy      = {1'b0, outstanding_q} + {1'b0, count_q};
      imem_req_valid = started_q && !redirect_valid && (occupancy < OW'(BUF_DEPTH));
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_drop       = imem_rsp_valid && (redirect_valid || state_q == DRAIN);
      push           = imem_rsp_valid && !rsp_drop;
      pop            = !redirect_valid && (count_q != '0) && dec_ready;

      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      if_rd_d       = if_rd_q;
      if_wr_d       = if_wr_q;
      if_pc_d       = if_pc_q;
      buf_pc_d      = buf_pc_q;
      buf_instr_d   = buf_instr_q;
      dec_instr_d   = dec_instr_q;
      dec_pc_d      = dec_pc_q;

      // The in-flight PC queue ignores redirects: memory still answers every accepted request.
      if (req_fire) begin
         if_pc_d[if_wr_q] = fetch_pc_q;
         if_wr_d          = if_wr_q + AW'(1);
         fetch_pc_d       = fetch_pc_q + XLEN'(4);
         outstanding_d    = outstanding_d + CW'(1);
      end
      if (imem_rsp_valid) begin
         if_rd_d       = if_rd_q + AW'(1);
         outstanding_d = outstanding_d - CW'(1);
      end

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~XLEN'(3);
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // Every request still in flight (including undrained residue) is now stale.
         drop_cnt_d = outstanding_d;
      end else begin
         if (rsp_drop)
            drop_cnt_d = drop_cnt_q - CW'(1);
         if (push) begin
            buf_pc_d[wr_ptr_q]    = if_pc_q[if_rd_q];
            buf_instr_d[wr_ptr_q] = imem_rsp_data;
            wr_ptr_d              = wr_ptr_q + AW'(1);
         end
         if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      state_d     = (drop_cnt_d != '0) ? DRAIN : RUN;
      dec_valid_d = (count_d != '0);
      if (dec_valid_d) begin
         dec_instr_d = buf_instr_d[rd_ptr_d];
         dec_pc_d    = buf_pc_d[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         started_q     <= 1'b0;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         if_rd_q       <= '0;
         if_wr_q       <= '0;
         if_pc_q       <= '{default: '0};
         buf_pc_q      <= '{default: '0};
         buf_instr_q   <= '{default: '0};
         dec_valid_q   <= 1'b0;
         dec_instr_q   <= NOP;
         dec_pc_q      <= '0;
      end else begin
         state_q       <= state_d;
         started_q     <= 1'b1;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         if_rd_q       <= if_rd_d;
         if_wr_q       <= if_wr_d;
         if_pc_q       <= if_pc_d;
         buf_pc_q      <= buf_pc_d;
         buf_instr_q   <= buf_instr_d;
         dec_valid_q   <= dec_valid_d;
         dec_instr_q   <= dec_instr_d;
         dec_pc_q      <= dec_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(imem_rsp_valid && outstanding_q == '0));
         assert (occupancy <= OW'(BUF_DEPTH));
         assert (drop_cnt_q <= outstanding_q);
      end
   end

   assign imem_req_addr = fetch_pc_q;
   assign dec_valid     = dec_valid_q;
   assign dec_instr     = dec_instr_q;
   assign dec_pc        = dec_pc_q;
   assign dec_opcode    = dec_instr_q[6:0];

endmodule
